counter_ctrl_buttons: RTL and testbench

- Upstream control stage for the N-bit up/down loadable counter.
- Takes three raw, bouncing, asynchronous push-button inputs and converts them into the counter's clean control inputs.
- Per button: 2-flop synchronizer, then debounce FSM, then press-edge detector.
- Outputs: one-cycle `load` pulse; `enable` and `dec` toggle levels. All connect directly to the counter's load/enable/dec ports.

---
 rtl/counter_ctrl_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 108 ++++++++++
 rtl/counter_ctrl_buttons.sv | 84 ++++++++
 tb/tb_counter_ctrl_buttons.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl_pkg
//  Description : Shared types and constants for the push-button control stage
//                of the up/down loadable counter (debounce FSM states and
//                button index map).
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

    // Debounce FSM states, shared by every button channel.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CHK_PRESS   = 2'd1,
        HELD        = 2'd2,
        CHK_RELEASE = 2'd3
    } dbnc_state_t;

    // Bit positions of each button inside the packed button vectors.
    localparam int BTN_LOAD   = 0;
    localparam int BTN_ENABLE = 1;
    localparam int BTN_DEC    = 2;
    localparam int NUM_BTN    = 3;

endpackage : counter_ctrl_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One push-button channel: 2-flop synchronizer, debounce FSM
//                with saturating stability counter, and a registered
//                one-cycle press pulse on each accepted press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press,
    output logic held
);

    localparam int                 CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    dbnc_state_t        r_state;
    dbnc_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_press;
    logic               w_press_nxt;

    // Bring the asynchronous button into the clock domain; FSM sees only r_sync2.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State, stability counter and press pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    // Debounce decisions: a level change is accepted only after the synced
    // input has been stable for DEBOUNCE_CYCLES samples. The counter leaves
    // its check state at the last count, so it never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = CHK_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_PRESS: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = CHK_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            CHK_RELEASE: begin
                if (r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign press = r_press;
    assign held  = (r_state == HELD) || (r_state == CHK_RELEASE);

endmodule : btn_debounce
`default_nettype wire

// File: rtl/counter_ctrl_buttons.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl_buttons
//  Description : Converts three raw, bouncing push buttons into the counter's
//                clean control inputs: a one-cycle load pulse and the
//                enable / dec toggle levels.
//                Optional macro CTRL_LOAD_STOPS_EN: an accepted load press
//                also clears enable in the same cycle (clear beats a
//                coincident enable toggle).
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl_buttons
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_load,
    input  logic       btn_enable,
    input  logic       btn_dec,
    output logic       load,
    output logic       enable,
    output logic       dec,
    output logic [2:0] btn_held
);

    logic [NUM_BTN-1:0] w_btn_raw;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_held;
    logic               r_enable;
    logic               r_dec;
    logic               w_enable_nxt;
    logic               w_dec_nxt;

    assign w_btn_raw[BTN_LOAD]   = btn_load;
    assign w_btn_raw[BTN_ENABLE] = btn_enable;
    assign w_btn_raw[BTN_DEC]    = btn_dec;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clock   (clock),
                .reset   (reset),
                .btn_raw (w_btn_raw[gi]),
                .press   (w_press[gi]),
                .held    (w_held[gi])
            );
        end
    endgenerate

    // New toggle levels. The press pulses are themselves registered, so the
    // outputs below are driven from flops only and change in the same cycle
    // as the load pulse appears.
    always_comb begin
        w_enable_nxt = r_enable ^ w_press[BTN_ENABLE];
`ifdef CTRL_LOAD_STOPS_EN
        if (w_press[BTN_LOAD]) begin
            w_enable_nxt = 1'b0;
        end
`endif
        w_dec_nxt = r_dec ^ w_press[BTN_DEC];
    end

    // Commit the toggle levels once their press pulse has been consumed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_enable <= 1'b0;
            r_dec    <= 1'b0;
        end else begin
            r_enable <= w_enable_nxt;
            r_dec    <= w_dec_nxt;
        end
    end

    assign load     = w_press[BTN_LOAD];
    assign enable   = w_enable_nxt;
    assign dec      = w_dec_nxt;
    assign btn_held = w_held;

endmodule : counter_ctrl_buttons
`default_nettype wire

// File: tb/tb_counter_ctrl_buttons.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_ctrl_buttons
//  Description : Directed self-checking bench for counter_ctrl_buttons with
//                DEBOUNCE_CYCLES = 4 (press visible after the 7th edge
//                counted from the first edge sampling the button high).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl_buttons;

`ifdef CTRL_LOAD_STOPS_EN
    localparam bit c_LOAD_STOPS_EN = 1'b1;
`else
    localparam bit c_LOAD_STOPS_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       btn_load;
    logic       btn_enable;
    logic       btn_dec;
    logic       load;
    logic       enable;
    logic       dec;
    logic [2:0] btn_held;

    int vectors;
    int miscompares;

    counter_ctrl_buttons #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_load   (btn_load),
        .btn_enable (btn_enable),
        .btn_dec    (btn_dec),
        .load       (load),
        .enable     (enable),
        .dec        (dec),
        .btn_held   (btn_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        reset = 1'b1; btn_load = 1'b1; btn_enable = 1'b1; btn_dec = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({load, enable, dec, btn_held} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {load, enable, dec, btn_held}, 6'b0);
            end
        end
        reset = 1'b0;
        // tick t lands after edge t-1; edge 0 is the first post-reset sample
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp = (t == 7) ? 6'b111111 : 6'b000000;
            vectors++;
            if ({load, enable, dec, btn_held} !== exp) begin
                miscompares++;
                $display("FAIL reset_release t=%0d got=%b exp=%b", t, {load, enable, dec, btn_held}, exp);
            end
        end
        btn_load = 1'b0; btn_enable = 1'b0; btn_dec = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({load, enable, dec, btn_held} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_clear got=%b exp=%b", {load, enable, dec, btn_held}, 6'b0);
        end
    endtask

    task automatic test_load_press();
        logic exp_load;
        logic exp_held;
        for (int t = 1; t <= 30; t++) begin
            btn_load = (t <= 20);
            tick();
            exp_load = (t == 7);
            exp_held = (t >= 7) && (t <= 26);
            vectors++;
            if (load !== exp_load) begin
                miscompares++;
                $display("FAIL load_pulse t=%0d load=%b exp=%b", t, load, exp_load);
            end
            vectors++;
            if (btn_held[0] !== exp_held) begin
                miscompares++;
                $display("FAIL load_held t=%0d held=%b exp=%b", t, btn_held[0], exp_held);
            end
        end
        vectors++;
        if ({enable, dec} !== 2'b00) begin
            miscompares++;
            $display("FAIL load_side_effect got=%b exp=%b", {enable, dec}, 2'b00);
        end
    endtask

    task automatic test_enable_bounce();
        logic [5:0] pat;
        logic       exp_en;
        pat = 6'b011011; // applied LSB first: 1,1,0,1,1,0
        for (int p = 0; p < 6; p++) begin
            btn_enable = pat[p];
            tick();
            vectors++;
            if (enable !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce p=%0d enable=%b exp=0", p, enable);
            end
        end
        btn_enable = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            vectors++;
            if ({enable, btn_held[1]} !== 2'b00) begin
                miscompares++;
                $display("FAIL bounce_settle t=%0d got=%b exp=00", t, {enable, btn_held[1]});
            end
        end
        for (int n = 0; n < 2; n++) begin
            for (int t = 1; t <= 20; t++) begin
                btn_enable = (t <= 10);
                tick();
                exp_en = (n == 0) ? (t >= 7) : (t < 7);
                vectors++;
                if (enable !== exp_en) begin
                    miscompares++;
                    $display("FAIL enable_toggle n=%0d t=%0d enable=%b exp=%b", n, t, enable, exp_en);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp;
        for (int t = 1; t <= 20; t++) begin
            btn_enable = (t <= 10);
            btn_dec    = (t <= 10);
            tick();
            exp = (t >= 7) ? 3'b011 : 3'b000;
            vectors++;
            if ({load, enable, dec} !== exp) begin
                miscompares++;
                $display("FAIL simultaneous t=%0d got=%b exp=%b", t, {load, enable, dec}, exp);
            end
        end
    endtask

    task automatic test_load_stops_en();
        logic [2:0] exp;
        logic       exp_en;
        for (int t = 1; t <= 20; t++) begin
            btn_load = (t <= 10);
            tick();
            exp_en = (c_LOAD_STOPS_EN && t >= 7) ? 1'b0 : 1'b1;
            exp = {(t == 7), exp_en, 1'b1};
            vectors++;
            if ({load, enable, dec} !== exp) begin
                miscompares++;
                $display("FAIL load_stops_en t=%0d got=%b exp=%b", t, {load, enable, dec}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic exp_dec;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        btn_dec = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            vectors++;
            if (dec !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_pre t=%0d dec=%b exp=0", t, dec);
            end
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({dec, btn_held} !== 4'b0) begin
            miscompares++;
            $display("FAIL mid_reset_pulse got=%b exp=%b", {dec, btn_held}, 4'b0);
        end
        reset = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            exp_dec = (t >= 7);
            vectors++;
            if (dec !== exp_dec) begin
                miscompares++;
                $display("FAIL mid_reset_post t=%0d dec=%b exp=%b", t, dec, exp_dec);
            end
        end
        btn_dec = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        btn_load    = 1'b0;
        btn_enable  = 1'b0;
        btn_dec     = 1'b0;
        test_reset();
        test_load_press();
        test_enable_bounce();
        test_simultaneous();
        test_load_stops_en();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_counter_ctrl_buttons
`default_nettype wire
